// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width, Gray conversions and
// the almost-full default. Used by both write and read pointer blocks.
package fifo_pkg;

  localparam int PTR_MAX = 32;

  typedef logic [PTR_MAX-1:0] ptr_max_t;

  // Pointers carry one extra wrap bit beyond the address.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int afull_default(input int aw);
    return (1 << aw) - 2;
  endfunction

  // Both conversions work on a zero-extended pointer.
  // Leading zeros do not change the low bits, so callers
  // size-cast the result back to their own width.
  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle between producer/synchronizer and fifo_wptr_full.
// master: producer side (drives requests, sync'd read ptr, clear).
// slave : the pointer block (drives memory write and status).
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);

  logic                  wr_en_i;
  logic [ADDR_WIDTH:0]   rptr_gray_sync_i;
  logic                  clr_ovf_i;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [ADDR_WIDTH:0]   wptr_gray_o;
  logic                  full_o;
  logic                  almost_full_o;
  logic [ADDR_WIDTH:0]   wr_level_o;
  logic                  overflow_o;

  modport master (
    output wr_en_i,
    output rptr_gray_sync_i,
    output clr_ovf_i,
    input  mem_we_o,
    input  waddr_o,
    input  wptr_gray_o,
    input  full_o,
    input  almost_full_o,
    input  wr_level_o,
    input  overflow_o
  );

  modport slave (
    input  wr_en_i,
    input  rptr_gray_sync_i,
    input  clr_ovf_i,
    output mem_we_o,
    output waddr_o,
    output wptr_gray_o,
    output full_o,
    output almost_full_o,
    output wr_level_o,
    output overflow_o
  );

endinterface

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-domain pointer and full/level/overflow controller.
// Ports: clk_i, rst_i (async, active-high); bus = fifo_wptr_full_if.slave
//   in : wr_en_i, rptr_gray_sync_i (already in clk_i domain), clr_ovf_i
//   out: mem_we_o, waddr_o, wptr_gray_o, full_o, almost_full_o,
//        wr_level_o, overflow_o
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = afull_default(ADDR_WIDTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  fifo_wptr_full_if.slave bus
);

  localparam int PW  = ptr_w(ADDR_WIDTH);
  localparam int MSB = PW - 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t AF_T = ptr_t'(AFULL_THRESH);
  localparam ptr_t ONE  = ptr_t'(1);

  ptr_t wbin_q;
  ptr_t wbin_d;
  ptr_t wgray_q;
  ptr_t wgray_d;
  ptr_t level_q;
  ptr_t level_d;
  ptr_t rbin_sync;
  ptr_t rgray_full;
  logic full_q;
  logic full_d;
  logic afull_q;
  logic afull_d;
  logic ovf_q;
  logic ovf_d;
  logic accept;

  always_comb begin
    accept    = bus.wr_en_i & ~full_q;
    wbin_d    = accept ? wbin_q + ONE : wbin_q;
    wgray_d   = ptr_t'(bin2gray(ptr_max_t'(wbin_d)));
    rbin_sync = ptr_t'(gray2bin(ptr_max_t'(bus.rptr_gray_sync_i)));

    // Full when write ptr is one lap ahead of the read ptr:
    // in Gray that is the top two bits inverted, rest equal.
    rgray_full = {~bus.rptr_gray_sync_i[MSB -: 2],
                  bus.rptr_gray_sync_i[MSB-2:0]};
    full_d     = (wgray_d == rgray_full);

    level_d = wbin_d - rbin_sync;
    afull_d = (level_d >= AF_T);

    // A dropped write outranks a same-cycle clear.
    ovf_d = ovf_q;
    if (bus.wr_en_i & full_q) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.mem_we_o      = accept;
  assign bus.waddr_o       = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wptr_gray_o   = wgray_q;
  assign bus.full_o        = full_q;
  assign bus.almost_full_o = afull_q;
  assign bus.wr_level_o    = level_q;
  assign bus.overflow_o    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_WIDTH=4, AFULL=14).
// Table vectors, corner sequences and a random run vs a count model.
module tb_fifo_wptr_full;

  logic clk;
  logic rst;
  logic clk_en;

  int checks = 0;
  int errors = 0;

  fifo_wptr_full_if #(.ADDR_WIDTH(4)) bus ();

  fifo_wptr_full #(
    .ADDR_WIDTH(4),
    .AFULL_THRESH(14)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  typedef struct {
    logic we;
    int   rb;
    logic clr;
    logic e_we;
    int   e_addr;
    int   e_lvl;
    logic e_full;
    logic e_af;
    logic e_ovf;
    int   e_gray;
  } vec_t;

  vec_t tbl[$];

  function automatic int g(input int x);
    return x ^ (x >> 1);
  endfunction

  function automatic vec_t mkv(
    input logic we, input int rb, input logic clr,
    input logic e_we, input int e_addr, input int e_lvl,
    input logic e_full, input logic e_af, input logic e_ovf,
    input int e_gray);
    vec_t v;
    v.we = we; v.rb = rb; v.clr = clr;
    v.e_we = e_we; v.e_addr = e_addr; v.e_lvl = e_lvl;
    v.e_full = e_full; v.e_af = e_af; v.e_ovf = e_ovf;
    v.e_gray = e_gray;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gray"},  32'(bus.wptr_gray_o), 0);
    chk({tag, ".level"}, 32'(bus.wr_level_o), 0);
    chk({tag, ".full"},  32'(bus.full_o), 0);
    chk({tag, ".af"},    32'(bus.almost_full_o), 0);
    chk({tag, ".ovf"},   32'(bus.overflow_o), 0);
    chk({tag, ".waddr"}, 32'(bus.waddr_o), 0);
  endtask

  // Model state: unbounded write/read counts.
  int   m_w;
  int   m_r;
  logic m_full;
  logic m_af;
  logic m_ovf;

  task automatic model_reset();
    m_w = 0; m_r = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.wr_en_i = 1'b0;
    bus.clr_ovf_i = 1'b0;
    bus.rptr_gray_sync_i = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int prev;
    int cur;
    bit seen_wrap;
    bit we;
    bit clr;
    int lvl;

    clk_en = 1'b0;
    rst = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.clr_ovf_i = 1'b0;
    bus.rptr_gray_sync_i = '0;

    // 1: reset with clock stopped
    #3 rst = 1'b1;
    #1 chk_all_zero("rst_noclk");
    #2 rst = 1'b0;
    bus.wr_en_i = 1'b1;
    #1;
    chk("rel.mem_we", 32'(bus.mem_we_o), 1);
    chk("rel.waddr", 32'(bus.waddr_o), 0);
    bus.wr_en_i = 1'b0;
    #1 clk_en = 1'b1;

    // 2-4: table
    for (int i = 0; i < 16; i++) begin
      tbl.push_back(mkv(1, 0, 0, 1, i, i + 1, i == 15,
                        (i + 1) >= 14, 0, g(i + 1)));
    end
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mkv(1, 0, 0, 0, 0, 16, 1, 1, 1, 24));
    end
    tbl.push_back(mkv(1, 0, 1, 0, 0, 16, 1, 1, 1, 24));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 16, 1, 1, 0, 24));
    tbl.push_back(mkv(0, 4, 0, 0, 0, 12, 0, 0, 0, 24));
    tbl.push_back(mkv(1, 4, 0, 1, 0, 13, 0, 0, 0, 25));

    foreach (tbl[k]) begin
      @(negedge clk);
      bus.wr_en_i = tbl[k].we;
      bus.clr_ovf_i = tbl[k].clr;
      bus.rptr_gray_sync_i = 5'(g(tbl[k].rb));
      #1;
      chk($sformatf("t%0d.mem_we", k), 32'(bus.mem_we_o),
          32'(tbl[k].e_we));
      chk($sformatf("t%0d.waddr", k), 32'(bus.waddr_o),
          32'(tbl[k].e_addr));
      @(posedge clk);
      #1;
      chk($sformatf("t%0d.level", k), 32'(bus.wr_level_o),
          32'(tbl[k].e_lvl));
      chk($sformatf("t%0d.full", k), 32'(bus.full_o),
          32'(tbl[k].e_full));
      chk($sformatf("t%0d.af", k), 32'(bus.almost_full_o),
          32'(tbl[k].e_af));
      chk($sformatf("t%0d.ovf", k), 32'(bus.overflow_o),
          32'(tbl[k].e_ovf));
      chk($sformatf("t%0d.gray", k), 32'(bus.wptr_gray_o),
          32'(tbl[k].e_gray));
    end

    // 5: wrap with reader two behind
    do_reset();
    seen_wrap = 0;
    prev = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      m_r = (m_w >= 2) ? m_w - 2 : 0;
      bus.rptr_gray_sync_i = 5'(g(m_r % 32));
      bus.wr_en_i = 1'b1;
      @(posedge clk);
      m_w++;
      #1;
      cur = int'(bus.wptr_gray_o);
      chk($sformatf("wrap%0d.onebit", k), $countones(prev ^ cur), 1);
      chk($sformatf("wrap%0d.gray", k), 32'(cur), 32'(g(m_w % 32)));
      chk($sformatf("wrap%0d.full", k), 32'(bus.full_o), 0);
      chk($sformatf("wrap%0d.level", k), 32'(bus.wr_level_o),
          32'(m_w - m_r));
      if (prev == 5'b10000 && cur == 0) seen_wrap = 1;
      prev = cur;
    end
    chk("wrap.seen", 32'(seen_wrap), 1);

    // 6: async reset mid-burst at level 9
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      bus.wr_en_i = 1'b1;
      @(posedge clk);
    end
    #1 chk("burst.level", 32'(bus.wr_level_o), 9);
    #1 rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    chk("rst_mid.mem_we", 32'(bus.mem_we_o), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst.waddr", 32'(bus.waddr_o), 0);
    chk("post_rst.mem_we", 32'(bus.mem_we_o), 1);
    @(posedge clk);
    #1;
    chk("post_rst.level", 32'(bus.wr_level_o), 1);
    chk("post_rst.gray", 32'(bus.wptr_gray_o), 1);

    // Random run against count model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      we  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if (m_r < m_w && $urandom_range(0, 2) == 0) m_r++;
      bus.wr_en_i = we;
      bus.clr_ovf_i = clr;
      bus.rptr_gray_sync_i = 5'(g(m_r % 32));
      #1;
      chk("rnd.mem_we", 32'(bus.mem_we_o), 32'(we & ~m_full));
      chk("rnd.waddr", 32'(bus.waddr_o), 32'(m_w % 16));
      @(posedge clk);
      if (we && m_full) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (we && !m_full) m_w++;
      lvl = m_w - m_r;
      m_full = (lvl == 16);
      m_af = (lvl >= 14);
      #1;
      chk("rnd.gray", 32'(bus.wptr_gray_o), 32'(g(m_w % 32)));
      chk("rnd.level", 32'(bus.wr_level_o), 32'(lvl));
      chk("rnd.full", 32'(bus.full_o), 32'(m_full));
      chk("rnd.af", 32'(bus.almost_full_o), 32'(m_af));
      chk("rnd.ovf", 32'(bus.overflow_o), 32'(m_ovf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
